// File: rtl/random_coord_gen.sv
// -----------------------------------------------------------------------------
// random_coord_gen
// Draws a pseudo-random (x, y) coordinate from a free-running Fibonacci LFSR.
// Each request samples candidates from successive LFSR states until one lies
// inside the legal box (x <= X_MAX, y <= Y_MAX) and differs from an optional
// excluded coordinate. After MAX_TRIES rejected candidates a deterministic
// fallback coordinate is returned instead, so latency is always bounded.
//
// Ports
//   system_clk  in   single clock, rising edge
//   reset       in   asynchronous active-high reset
//   req         in   request a coordinate (sampled only while idle)
//   seed_load   in   load seed_in into the LFSR on this edge
//   seed_in     in   reseed value (zero is replaced by SEED)
//   excl_valid  in   exclusion coordinate enabled
//   excl_x/y    in   coordinate the result must not equal
//   busy        out  draw in progress
//   valid       out  one-cycle pulse, x_out/y_out hold a new result
//   x_out/y_out out  result coordinate, held between requests
//   fallback    out  last result came from the fallback path
//   lfsr_q      out  current LFSR state
// -----------------------------------------------------------------------------
module random_coord_gen #(
    parameter int                LFSR_W    = 16,
    parameter int                X_W       = 4,
    parameter int                Y_W       = 4,
    parameter int                X_MAX     = 15,
    parameter int                Y_MAX     = 11,
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
    parameter int                MAX_TRIES = 8
) (
    input  logic              system_clk,
    input  logic              reset,
    input  logic              req,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    input  logic              excl_valid,
    input  logic [X_W-1:0]    excl_x,
    input  logic [Y_W-1:0]    excl_y,
    output logic              busy,
    output logic              valid,
    output logic [X_W-1:0]    x_out,
    output logic [Y_W-1:0]    y_out,
    output logic              fallback,
    output logic [LFSR_W-1:0] lfsr_q
);

    localparam int             TRY_W    = $clog2(MAX_TRIES + 1);
    localparam logic [X_W-1:0] X_MAX_C  = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_MAX_C  = Y_W'(Y_MAX);
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DRAW     = 2'd1,
        S_FALLBACK = 2'd2
    } state_t;

    state_t            r_state;
    logic [LFSR_W-1:0] r_lfsr;
    logic [TRY_W-1:0]  r_tries;
    logic              r_busy;
    logic              r_valid;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic              r_fallback;

    logic              w_fb;
    logic [LFSR_W-1:0] w_seed_next;
    logic [X_W-1:0]    w_cx;
    logic [Y_W-1:0]    w_cy;
    logic              w_accept;
    logic              w_excl_zero;

    // Feedback taps chosen per width; unused widths are never elaborated.
    generate
        if (LFSR_W == 8) begin : g_fb8
            assign w_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
        end else if (LFSR_W == 32) begin : g_fb32
            assign w_fb = r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0];
        end else begin : g_fb16
            assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
        end
    endgenerate

    // Candidate extraction, acceptance test and reseed value selection.
    always_comb begin
        w_cx        = r_lfsr[X_W-1:0];
        w_cy        = r_lfsr[X_W+Y_W-1:X_W];
        w_accept    = (w_cx <= X_MAX_C) && (w_cy <= Y_MAX_C) &&
                      !(excl_valid && (w_cx == excl_x) && (w_cy == excl_y));
        w_excl_zero = excl_valid && (excl_x == {X_W{1'b0}}) && (excl_y == {Y_W{1'b0}});
        // A zero seed would lock the LFSR, so it is replaced by SEED.
        if (seed_in == {LFSR_W{1'b0}}) begin
            w_seed_next = SEED;
        end else begin
            w_seed_next = seed_in;
        end
    end

    // LFSR stepping/reseed and the draw state machine with registered outputs.
    always_ff @(posedge system_clk or posedge reset) begin
        if (reset) begin
            r_lfsr     <= SEED;
            r_state    <= S_IDLE;
            r_tries    <= {TRY_W{1'b0}};
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_x        <= {X_W{1'b0}};
            r_y        <= {Y_W{1'b0}};
            r_fallback <= 1'b0;
        end else begin
            if (seed_load) begin
                r_lfsr <= w_seed_next;
            end else begin
                r_lfsr <= {r_lfsr[LFSR_W-2:0], w_fb};
            end

            r_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_state <= S_DRAW;
                        r_tries <= {TRY_W{1'b0}};
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                S_DRAW: begin
                    if (w_accept) begin
                        r_x        <= w_cx;
                        r_y        <= w_cy;
                        r_fallback <= 1'b0;
                        r_valid    <= 1'b1;
                        r_state    <= S_IDLE;
                        r_busy     <= 1'b0;
                    end else if (r_tries == TRY_LAST) begin
                        // This reject exhausts the budget.
                        r_tries <= r_tries + TRY_W'(1);
                        r_state <= S_FALLBACK;
                    end else begin
                        r_tries <= r_tries + TRY_W'(1);
                    end
                end
                S_FALLBACK: begin
                    // (0,0) unless it is the excluded point; X_MAX >= 1 makes (1,0) legal.
                    if (w_excl_zero) begin
                        r_x <= {{(X_W-1){1'b0}}, 1'b1};
                    end else begin
                        r_x <= {X_W{1'b0}};
                    end
                    r_y        <= {Y_W{1'b0}};
                    r_fallback <= 1'b1;
                    r_valid    <= 1'b1;
                    r_state    <= S_IDLE;
                    r_busy     <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign valid    = r_valid;
    assign x_out    = r_x;
    assign y_out    = r_y;
    assign fallback = r_fallback;
    assign lfsr_q   = r_lfsr;

endmodule

// File: tb/tb_random_coord_gen.sv
// -----------------------------------------------------------------------------
// tb_random_coord_gen
// Two instances share all stimulus: u_dut1 uses default parameters, u_dut2 uses
// MAX_TRIES=2 so the fallback path is reached. Each request pushes the expected
// result and arrival cycle into a per-instance queue; a negedge monitor pops
// and compares whenever valid is seen.
// -----------------------------------------------------------------------------
module tb_random_coord_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        excl_valid;
    logic [3:0]  excl_x;
    logic [3:0]  excl_y;

    logic        busy1, valid1, fb1, busy2, valid2, fb2;
    logic [3:0]  x1, y1, x2, y2;
    logic [15:0] lfsr1, lfsr2;

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic       fb;
        int         cyc;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    random_coord_gen u_dut1 (
        .system_clk(clk), .reset(reset), .req(req), .seed_load(seed_load),
        .seed_in(seed_in), .excl_valid(excl_valid), .excl_x(excl_x), .excl_y(excl_y),
        .busy(busy1), .valid(valid1), .x_out(x1), .y_out(y1), .fallback(fb1),
        .lfsr_q(lfsr1)
    );

    random_coord_gen #(.MAX_TRIES(2)) u_dut2 (
        .system_clk(clk), .reset(reset), .req(req), .seed_load(seed_load),
        .seed_in(seed_in), .excl_valid(excl_valid), .excl_x(excl_x), .excl_y(excl_y),
        .busy(busy2), .valid(valid2), .x_out(x2), .y_out(y2), .fallback(fb2),
        .lfsr_q(lfsr2)
    );

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Called just after a posedge, with req driven for the next edge.
    task automatic expect_both(input logic [3:0] ex1, input logic [3:0] ey1, input logic ef1,
                               input int l1, input logic [3:0] ex2, input logic [3:0] ey2,
                               input logic ef2, input int l2);
        exp_t e;
        e.x = ex1; e.y = ey1; e.fb = ef1; e.cyc = cyc + 1 + l1;
        q1.push_back(e);
        e.x = ex2; e.y = ey2; e.fb = ef2; e.cyc = cyc + 1 + l2;
        q2.push_back(e);
    endtask

    task automatic wait_idle;
        for (int i = 0; i < 20 && (busy1 || busy2); i++) step;
        cmp("idle_timeout", {31'd0, busy1 | busy2}, 32'd0);
        step;
    endtask

    task automatic issue(input logic [15:0] sd, input logic ev, input logic [3:0] ex,
                         input logic [3:0] ey, input logic [3:0] ex1, input logic [3:0] ey1,
                         input logic ef1, input int l1, input logic [3:0] ex2,
                         input logic [3:0] ey2, input logic ef2, input int l2);
        seed_load  = 1'b1;
        seed_in    = sd;
        excl_valid = ev;
        excl_x     = ex;
        excl_y     = ey;
        req        = 1'b1;
        expect_both(ex1, ey1, ef1, l1, ex2, ey2, ef2, l2);
        step;
        seed_load = 1'b0;
        req       = 1'b0;
        cmp("busy1_after_req", {31'd0, busy1}, 32'd1);
        cmp("busy2_after_req", {31'd0, busy2}, 32'd1);
        wait_idle;
    endtask

    // Scoreboard monitor for u_dut1.
    always @(negedge clk) begin
        if (valid1) begin
            if (q1.size() == 0) begin
                cmp("dut1_unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q1.pop_front();
                cmp("dut1_x", {28'd0, x1}, {28'd0, e.x});
                cmp("dut1_y", {28'd0, y1}, {28'd0, e.y});
                cmp("dut1_fallback", {31'd0, fb1}, {31'd0, e.fb});
                cmp("dut1_latency", cyc, e.cyc);
            end
        end
    end

    // Scoreboard monitor for u_dut2.
    always @(negedge clk) begin
        if (valid2) begin
            if (q2.size() == 0) begin
                cmp("dut2_unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q2.pop_front();
                cmp("dut2_x", {28'd0, x2}, {28'd0, e.x});
                cmp("dut2_y", {28'd0, y2}, {28'd0, e.y});
                cmp("dut2_fallback", {31'd0, fb2}, {31'd0, e.fb});
                cmp("dut2_latency", cyc, e.cyc);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        cmp({tag, "_lfsr1"}, {16'd0, lfsr1}, 32'h0000ACE1);
        cmp({tag, "_lfsr2"}, {16'd0, lfsr2}, 32'h0000ACE1);
        cmp({tag, "_busy"}, {30'd0, busy1, busy2}, 32'd0);
        cmp({tag, "_valid"}, {30'd0, valid1, valid2}, 32'd0);
        cmp({tag, "_xy1"}, {24'd0, x1, y1}, 32'd0);
        cmp({tag, "_xy2"}, {24'd0, x2, y2}, 32'd0);
        cmp({tag, "_fallback"}, {30'd0, fb1, fb2}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; req = 1'b0; seed_load = 1'b0; seed_in = 16'h0000;
        excl_valid = 1'b0; excl_x = 4'd0; excl_y = 4'd0;
        repeat (3) step;
        check_reset_outputs("reset");
        reset = 1'b0;

        // Zero seed is substituted by ACE1, then one LFSR step gives 59C3.
        seed_load = 1'b1; seed_in = 16'h0000;
        step;
        seed_load = 1'b0;
        cmp("seed_zero_subst", {16'd0, lfsr1}, 32'h0000ACE1);
        step;
        cmp("lfsr_step", {16'd0, lfsr1}, 32'h000059C3);

        // Seed 00A3 with req: first candidate (3,10) accepted.
        issue(16'h00A3, 1'b0, 4'd0, 4'd0, 4'd3, 4'd10, 1'b0, 1, 4'd3, 4'd10, 1'b0, 1);
        // Excluding (3,10): next state 0146 gives (6,4).
        issue(16'h00A3, 1'b1, 4'd3, 4'd10, 4'd6, 4'd4, 1'b0, 2, 4'd6, 4'd4, 1'b0, 2);
        // Three y-rejects then 0798 -> (8,9); MAX_TRIES=2 falls back to (0,0).
        issue(16'h00F3, 1'b0, 4'd0, 4'd0, 4'd8, 4'd9, 1'b0, 4, 4'd0, 4'd0, 1'b1, 3);
        // Same with (0,0) excluded: fallback becomes (1,0).
        issue(16'h00F3, 1'b1, 4'd0, 4'd0, 4'd8, 4'd9, 1'b0, 4, 4'd1, 4'd0, 1'b1, 3);
        cmp("fallback_held", {31'd0, fb2}, 32'd1);

        // Back-to-back: req held into the valid cycle starts a draw from 028C -> (12,8).
        excl_valid = 1'b0;
        seed_load = 1'b1; seed_in = 16'h00A3; req = 1'b1;
        expect_both(4'd3, 4'd10, 1'b0, 1, 4'd3, 4'd10, 1'b0, 1);
        step;
        seed_load = 1'b0;
        step;
        cmp("b2b_valid_cycle_idle", {31'd0, busy1}, 32'd0);
        expect_both(4'd12, 4'd8, 1'b0, 1, 4'd12, 4'd8, 1'b0, 1);
        step;
        req = 1'b0;
        wait_idle;

        // Reseed mid-draw: 00F3 rejected, then loaded 00A3 accepted.
        seed_load = 1'b1; seed_in = 16'h00F3; req = 1'b1;
        expect_both(4'd3, 4'd10, 1'b0, 2, 4'd3, 4'd10, 1'b0, 2);
        step;
        seed_in = 16'h00A3; req = 1'b0;
        step;
        seed_load = 1'b0;
        wait_idle;

        // Reset mid-draw (req pulsed while busy): no valid, outputs cleared.
        seed_load = 1'b1; seed_in = 16'h00F3; req = 1'b1;
        step;
        seed_load = 1'b0; req = 1'b1;
        step;
        req = 1'b0;
        reset = 1'b1;
        #1;
        check_reset_outputs("midreset");
        // req held through release: sampled on first edge, 59C3 rejected, B387 -> (7,8).
        req = 1'b1;
        step;
        step;
        reset = 1'b0;
        expect_both(4'd7, 4'd8, 1'b0, 2, 4'd7, 4'd8, 1'b0, 2);
        step;
        req = 1'b0;
        wait_idle;

        repeat (5) step;
        cmp("dut1_missing_results", q1.size(), 32'd0);
        cmp("dut2_missing_results", q2.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/random_coord_gen.md
RANDOM_COORD_GEN -- requirements
Module: random_coord_gen

Interface
REQ-001 Parameter LFSR_W, default 16, LFSR width; legal values 8, 16, 32 only.
REQ-002 Parameter X_W, default 4, x coordinate width; Y_W, default 4, y coordinate width; X_W+Y_W SHALL be <= LFSR_W.
REQ-003 Parameter X_MAX, default 15, largest legal x (inclusive, 1..2^X_W-1); Y_MAX, default 11, largest legal y (inclusive, 0..2^Y_W-1).
REQ-004 Parameter SEED, default 16'hACE1 (LFSR_W bits, nonzero), reset and zero-substitute seed.
REQ-005 Parameter MAX_TRIES, default 8, rejected draws allowed before fallback (>=1).
REQ-006 system_clk  in  1  single clock, all state changes on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 req  in  1  request a new coordinate; sampled only in IDLE.
REQ-009 seed_load  in  1  load seed_in into LFSR this edge.
REQ-010 seed_in  in  LFSR_W  reseed value.
REQ-011 excl_valid  in  1  exclusion coordinate enabled.
REQ-012 excl_x  in  X_W / excl_y  in  Y_W  coordinate the result must not equal; held stable by user while busy.
REQ-013 busy  out  1  draw in progress (state not IDLE).
REQ-014 valid  out  1  one-cycle pulse: x_out/y_out hold a new result.
REQ-015 x_out  out  X_W / y_out  out  Y_W  result coordinate, held between requests.
REQ-016 fallback  out  1  last result came from fallback path, held with result.
REQ-017 lfsr_q  out  LFSR_W  current LFSR state (debug/verification).

Function
REQ-018 LFSR SHALL be Fibonacci, free-running, one step every cycle: lfsr <= {lfsr[LFSR_W-2:0], fb}.
REQ-019 fb SHALL be: W=8 bits 7^5^4^3; W=16 bits 15^13^12^10; W=32 bits 31^21^1^0.
REQ-020 seed_load SHALL override stepping for that edge: lfsr <= seed_in, or SEED when seed_in==0 (all-zero lockup never reachable).
REQ-021 FSM states IDLE, DRAW, FALLBACK; IDLE->DRAW on req; req outside IDLE SHALL be ignored.
REQ-022 In DRAW, candidate cx=lfsr_q[X_W-1:0], cy=lfsr_q[X_W+Y_W-1:X_W], evaluated from the current-cycle lfsr_q.
REQ-023 Candidate accepted iff cx<=X_MAX and cy<=Y_MAX and not (excl_valid and cx==excl_x and cy==excl_y).
REQ-024 On accept: at that edge x_out<=cx, y_out<=cy, fallback<=0, valid<=1, state<=IDLE.
REQ-025 On reject: try counter increments; on reaching MAX_TRIES state<=FALLBACK, else remain in DRAW.
REQ-026 FALLBACK (one cycle): result (0,0), or (1,0) if excl_valid and excl=(0,0); fallback<=1, valid<=1, state<=IDLE.
REQ-027 Latency: valid high the cycle after the accepting edge; minimum 1 cycle after req sampled, maximum MAX_TRIES+1.
REQ-028 valid SHALL be high exactly one cycle per accepted req; try counter cleared on entering DRAW.
REQ-029 req high during the valid cycle (state IDLE) SHALL start a new draw (back-to-back requests supported).
REQ-030 seed_load during DRAW SHALL take effect; next candidate uses the new LFSR value, draw continues.
REQ-031 seed_load and req on the same edge: first candidate = loaded seed.

Reset
REQ-032 While reset high: lfsr_q=SEED, state IDLE, busy=0, valid=0, x_out=0, y_out=0, fallback=0, try counter=0.
REQ-033 Reset mid-draw SHALL abort the draw with no valid pulse; req held through reset release is sampled only on the first edge after release.

Verification (defaults unless stated)
REQ-034 seed_load=1, seed_in=0 -> lfsr_q=16'hACE1 next cycle, then 16'h59C3.
REQ-035 seed_load=1, seed_in=16'h00A3, req=1 same edge -> one cycle later valid=1, x_out=3, y_out=10, fallback=0.
REQ-036 As REQ-035 with excl_valid=1, excl=(3,10) -> reject, then valid with x_out=6, y_out=4 (LFSR 16'h0146), latency 2.
REQ-037 seed_in=16'h00F3 with req -> rejects 00F3 (y=15), 01E6 (y=14), 03CC (y=12); accepts 0798 -> x_out=8, y_out=9, latency 4.
REQ-038 MAX_TRIES=2, seed_in=16'h00F3 -> valid after 3 cycles, (0,0), fallback=1; with excl=(0,0) -> (1,0), fallback=1.
REQ-039 Assert reset during DRAW of REQ-037 -> no valid, all outputs at reset values; req during busy produces no extra valid.
